i2s_tx: RTL and testbench
=========================

Name: i2s_tx

Overview:
- Transmit-side I2S serializer for the Pmod I2S2 line-out.
- Converts the deserializing receive path back into a serial stream: accepts parallel stereo 24-bit samples on a valid/ready interface and drives master-mode mclk/lrck/sclk/sdout.
- Sits between the tuner's audio-output logic (reference-tone playback) and the line-out pins, replacing the piso + AXIS transmit path.

Parameters:
- width_p, 24, sample width per channel in bits.
- sclk_div_p, 8, clk_i cycles per sclk period; power of two, >= 4.
- slot_bits_p, 32, sclk periods per channel slot; power of two, >= width_p+1.

Ports:
- clk_i  in  1  system clock (22.5 MHz PLL output).
- reset_n_i  in  1  asynchronous active-low reset.
- valid_i  in  1  stereo sample offered.
- ready_o  out  1  holding register empty; sample accepted when valid_i & ready_o.
- data_left_i  in  width_p  left sample, two's complement.
- data_right_i  in  width_p  right sample, two's complement.
- mclk_o  out  1  main clock, clk_i/2.
- lrck_o  out  1  channel select: 0 = left, 1 = right.
- sclk_o  out  1  serial bit clock.
- sdout_o  out  1  serial data, MSB first.
- underflow_o  out  1  one-cycle pulse when a frame starts with no new sample.

Behaviour:
- Reset values (async on reset_n_i low): frame counter 0, all outputs 0, holding empty (ready_o = 0 while in reset, 1 on the first clk after release), shift registers 0, primed flag 0.
- Frame counter:
  - Free-running, F = 2*slot_bits_p*sclk_div_p cycles (default 512; fs = 43.9 kHz), wraps F-1 -> 0.
  - Let S = log2(sclk_div_p); bit index b = counter >> S (0..2*slot_bits_p-1); slot = MSB of b; pos = b mod slot_bits_p.
- Output derivation (all outputs registered from counter state, so they lag the counter by 1 clk):
  - mclk_o = counter bit 0.
  - sclk_o = counter bit S-1: low in the first half of each bit, so sdout changes on sclk falling edges.
  - lrck_o = slot.
  - sdout_o: pos 0 -> 0 (I2S one-bit delay); pos 1..width_p -> channel sample bit width_p-pos (MSB first); pos > width_p -> 0.
- Holding register:
  - ready_o = ~hold_full.
  - On accept: latch both channels and set hold_full and primed.
- Frame start (counter == 0):
  - If hold_full: copy holding into left/right shift registers and clear hold_full.
  - Otherwise: underflow. Shift registers follow the optional feature. underflow_o pulses only if primed = 1.
- Simultaneous accept and frame start with hold_full = 0: no bypass. The sample is latched into holding, the current frame underflows, and the sample plays next frame.
- Latency: a sample accepted at least 1 clk before frame start has its left MSB on sdout_o at counter = sclk_div_p + 1.
- Timing is never stalled by handshake state.
- Reset mid-frame: immediate return to reset values; the next frame starts from counter 0; the partially sent sample is lost.

Optional Feature:
- Macro: I2S_TX_HOLD_LAST_EN.
- Defined: on underflow, the shift registers reload the last transmitted sample, so the last sample repeats.
- Undefined: on underflow, the shift registers load zero, so silence is sent.
- underflow_o behaves identically in both builds.

Decomposition:
- Package i2s_pkg holds:
  - frame-length localparams derived from the default parameters;
  - typedef stereo_sample_t (packed struct of left/right, width_p bits each);
  - the slot encoding constants LEFT = 0, RIGHT = 1.
- Sub-module i2s_clkgen holds the frame counter and the registered mclk/sclk/lrck, and exports b and a frame-start strobe.
- i2s_tx holds the handshake, holding register and shift/select logic.

Test Plan:
- Reset release, no valid_i: mclk_o period 2 clk, sclk_o period 8 clk, lrck_o period 512 clk with 50% duty; sdout_o = 0; underflow_o never pulses (not primed).
- Send left = 24'h800001, right = 24'h7FFFFE before frame start: sampling sdout_o on sclk rising edges gives pos 0 = 0, pos 1..24 = 0x800001 (left slot) and 0x7FFFFE (right slot), pos 25..31 = 0.
- Back-to-back valid_i held high: ready_o drops after accept and rises 1 clk after each frame start; exactly one sample per 512 clk; no underflow_o.
- Stop sending after sample 0x123456: underflow_o pulses once per frame. With I2S_TX_HOLD_LAST_EN, 0x123456 repeats; without it, all-zero slots.
- valid_i asserted exactly at counter = 0 with holding empty: underflow_o pulses; sample appears in the following frame.
- Assert reset_n_i low mid-right-slot: all outputs 0 within the same cycle; after release, the timing pattern restarts from counter 0.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S transmit path.
package i2s_pkg;

  localparam int WIDTH     = 24;
  localparam int SCLK_DIV  = 8;
  localparam int SLOT_BITS = 32;
  localparam int FRAME_LEN = 2 * SLOT_BITS * SCLK_DIV;
  localparam int CNT_W     = $clog2(FRAME_LEN);
  localparam int BIT_W     = $clog2(2 * SLOT_BITS);

  typedef struct packed {
    logic [WIDTH-1:0] left;
    logic [WIDTH-1:0] right;
  } stereo_sample_t;

  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

endpackage

// File: rtl/i2s_clkgen.sv
// Free-running frame counter producing registered mclk/sclk/lrck, the current
// bit index within the frame and a frame-start strobe.
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter int sclk_div_p  = SCLK_DIV,
  parameter int slot_bits_p = SLOT_BITS
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  output logic [$clog2(slot_bits_p):0]   bit_idx_o,
  output logic                           frame_start_o,
  output logic                           mclk_o,
  output logic                           sclk_o,
  output logic                           lrck_o
);

  localparam int S  = $clog2(sclk_div_p);
  localparam int P  = $clog2(slot_bits_p);
  localparam int CW = S + P + 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          mclk_q, mclk_d;
  logic          sclk_q, sclk_d;
  logic          lrck_q, lrck_d;

  // Frame length is a power of two, so natural wrap gives F-1 -> 0.
  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    mclk_d = cnt_q[0];
    sclk_d = cnt_q[S-1];
    lrck_d = cnt_q[CW-1];
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q  <= '0;
      mclk_q <= 1'b0;
      sclk_q <= 1'b0;
      lrck_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      mclk_q <= mclk_d;
      sclk_q <= sclk_d;
      lrck_q <= lrck_d;
    end
  end

  assign bit_idx_o     = cnt_q[CW-1:S];
  assign frame_start_o = (cnt_q == '0);
  assign mclk_o        = mclk_q;
  assign sclk_o        = sclk_q;
  assign lrck_o        = lrck_q;

endmodule

// File: rtl/i2s_tx.sv
// Master-mode I2S transmitter: valid/ready stereo input, one-deep holding register.
// Build option I2S_TX_HOLD_LAST_EN: repeat the last sample on underflow instead of silence.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int width_p     = WIDTH,
  parameter int sclk_div_p  = SCLK_DIV,
  parameter int slot_bits_p = SLOT_BITS
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_left_i,
  input  logic [width_p-1:0] data_right_i,
  output logic               mclk_o,
  output logic               lrck_o,
  output logic               sclk_o,
  output logic               sdout_o,
  output logic               underflow_o
);

  localparam int P  = $clog2(slot_bits_p);
  localparam int IW = $clog2(width_p);
  localparam logic [P-1:0] WPOS = P'(width_p);

  logic [P:0]         bit_idx;
  logic               frame_start;
  logic [P-1:0]       pos;
  logic               slot;

  logic               hold_full_q, hold_full_d;
  logic               primed_q, primed_d;
  logic               ready_q, ready_d;
  logic               underflow_q, underflow_d;
  logic               sdout_q, sdout_d;
  logic [width_p-1:0] hold_l_q, hold_l_d;
  logic [width_p-1:0] hold_r_q, hold_r_d;
  logic [width_p-1:0] sr_l_q, sr_l_d;
  logic [width_p-1:0] sr_r_q, sr_r_d;
  logic [width_p-1:0] chan;
  logic [IW-1:0]      idx;
  logic               accept;

  i2s_clkgen #(
    .sclk_div_p  (sclk_div_p),
    .slot_bits_p (slot_bits_p)
  ) u_clkgen (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .bit_idx_o     (bit_idx),
    .frame_start_o (frame_start),
    .mclk_o        (mclk_o),
    .sclk_o        (sclk_o),
    .lrck_o        (lrck_o)
  );

  assign pos    = bit_idx[P-1:0];
  assign slot   = bit_idx[P];
  assign accept = valid_i & ready_q;

  always_comb begin
    hold_full_d = hold_full_q;
    primed_d    = primed_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    sr_l_d      = sr_l_q;
    sr_r_d      = sr_r_q;
    underflow_d = 1'b0;

    if (accept) begin
      hold_l_d    = data_left_i;
      hold_r_d    = data_right_i;
      hold_full_d = 1'b1;
      primed_d    = 1'b1;
    end

    // Frame start looks only at the old hold state: a sample accepted on this
    // same edge waits for the next frame rather than bypassing into this one.
    if (frame_start) begin
      if (hold_full_q) begin
        sr_l_d      = hold_l_q;
        sr_r_d      = hold_r_q;
        hold_full_d = 1'b0;
      end else begin
        underflow_d = primed_q;
`ifdef I2S_TX_HOLD_LAST_EN
        sr_l_d = sr_l_q;
        sr_r_d = sr_r_q;
`else
        sr_l_d = '0;
        sr_r_d = '0;
`endif
      end
    end

    ready_d = ~hold_full_d;
  end

  // Slot position 0 is the I2S one-bit delay; payload MSB goes out at position 1.
  always_comb begin
    chan    = (slot == RIGHT) ? sr_r_q : sr_l_q;
    idx     = IW'(WPOS - pos);
    sdout_d = 1'b0;
    if ((pos != '0) && (pos <= WPOS)) begin
      sdout_d = chan[idx];
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      hold_full_q <= 1'b0;
      primed_q    <= 1'b0;
      ready_q     <= 1'b0;
      underflow_q <= 1'b0;
      sdout_q     <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      sr_l_q      <= '0;
      sr_r_q      <= '0;
    end else begin
      hold_full_q <= hold_full_d;
      primed_q    <= primed_d;
      ready_q     <= ready_d;
      underflow_q <= underflow_d;
      sdout_q     <= sdout_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      sr_l_q      <= sr_l_d;
      sr_r_q      <= sr_r_d;
    end
  end

  assign ready_o     = ready_q;
  assign sdout_o     = sdout_q;
  assign underflow_o = underflow_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: frame scoreboard fed at accept time, checked per frame.
module tb_i2s_tx;
  import i2s_pkg::*;

  localparam int F = FRAME_LEN;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [23:0] dl = '0;
  logic [23:0] dr = '0;
  logic        ready, mclk, lrck, sclk, sdout, uf;

  always #5 clk = ~clk;

  i2s_tx dut (
    .clk_i        (clk),
    .reset_n_i    (rst_n),
    .valid_i      (valid),
    .ready_o      (ready),
    .data_left_i  (dl),
    .data_right_i (dr),
    .mclk_o       (mclk),
    .lrck_o       (lrck),
    .sclk_o       (sclk),
    .sdout_o      (sdout),
    .underflow_o  (uf)
  );

  typedef struct {
    int             frame;
    stereo_sample_t s;
  } exp_t;

  exp_t           exp_q[$];
  int             tests = 0;
  int             fails = 0;
  int             tcnt = 0;
  int             frame_k = -1;
  bit             outs_valid = 1'b0;
  int             primed_from = 1 << 30;
  int             frames_checked = 0;
  int             pc;
  logic [63:0]    cap = '0;
  logic           sclk_prev = 1'b0;
  logic           exp_uf;
  stereo_sample_t last_s = '0;
  stereo_sample_t es;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] frame_bits(input stereo_sample_t s);
    logic [63:0] v;
    logic [23:0] ch;
    int          p;
    v = '0;
    for (int b = 0; b < 64; b++) begin
      p  = b % 32;
      ch = (b < 32) ? s.left : s.right;
      if (p >= 1 && p <= 24) v[b] = ch[24-p];
    end
    return v;
  endfunction

  // Mirror of the DUT frame counter: value before each edge equals the DUT count.
  always @(posedge clk) begin
    if (!rst_n) begin
      tcnt       <= 0;
      frame_k    <= -1;
      outs_valid <= 1'b0;
    end else begin
      if (tcnt == 0) frame_k <= frame_k + 1;
      tcnt       <= (tcnt + 1) % F;
      outs_valid <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      cap       <= '0;
      sclk_prev <= 1'b0;
    end else if (outs_valid) begin
      pc = (tcnt + F - 1) % F;
      check("mclk", 64'(mclk), 64'(pc[0]));
      check("sclk", 64'(sclk), 64'(pc[2]));
      check("lrck", 64'(lrck), 64'(pc[8]));

      exp_uf = (tcnt == 1) && (primed_from <= frame_k) &&
               !(exp_q.size() > 0 && exp_q[0].frame == frame_k);
      check("underflow", 64'(uf), 64'(exp_uf));

      if (tcnt == 8) check("pos0_zero", 64'(sdout), 64'(0));
      if (tcnt == 9 && exp_q.size() > 0 && exp_q[0].frame == frame_k)
        check("left_msb_latency", 64'(sdout), 64'(exp_q[0].s.left[23]));

      if (sclk && !sclk_prev) begin
        cap[pc/8] <= sdout;
        if (pc / 8 == 63) begin
          if (exp_q.size() > 0 && exp_q[0].frame < frame_k) begin
            check("sample_lost", 64'(exp_q[0].frame), 64'(frame_k));
            void'(exp_q.pop_front());
          end
          if (exp_q.size() > 0 && exp_q[0].frame == frame_k) begin
            es     = exp_q[0].s;
            last_s = es;
            void'(exp_q.pop_front());
          end else begin
`ifdef I2S_TX_HOLD_LAST_EN
            es = last_s;
`else
            es = '0;
`endif
          end
          check($sformatf("frame%0d_bits", frame_k), {sdout, cap[62:0]}, frame_bits(es));
          frames_checked++;
        end
      end
      sclk_prev <= sclk;
    end
  end

  task automatic wait_cnt(input int c);
    for (int i = 0; i < F + 4 && tcnt != c; i++) @(negedge clk);
    check("wait_cnt", 64'(tcnt), 64'(c));
  endtask

  task automatic send(input logic [23:0] l, input logic [23:0] r, input bit keep);
    bit   waited;
    bit   done;
    exp_t e;
    waited = 1'b0;
    done   = 1'b0;
    dl     = l;
    dr     = r;
    valid  = 1'b1;
    for (int i = 0; i < 2 * F && !done; i++) begin
      if (ready) begin
        e.frame   = (tcnt == 0) ? frame_k + 2 : frame_k + 1;
        e.s.left  = l;
        e.s.right = r;
        if (waited) check("ready_rise_after_frame_start", 64'(tcnt), 64'(1));
        if (primed_from > e.frame) primed_from = e.frame;
        exp_q.push_back(e);
        done = 1'b1;
        @(negedge clk);
        check("ready_drop_after_accept", 64'(ready), 64'(0));
        if (!keep) valid = 1'b0;
      end else begin
        waited = 1'b1;
        @(negedge clk);
      end
    end
    check("accept_seen", 64'(done), 64'(1));
    $display("[TB] sent L=%06h R=%06h", l, r);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({ready, mclk, sclk, lrck, sdout, uf}), 64'(0));
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", 64'(ready), 64'(1));

    // Idle: timing only, silent frames, no underflow before priming.
    repeat (2 * F + 20) @(negedge clk);

    wait_cnt(100);
    send(24'h800001, 24'h7FFFFE, 1'b0);
    repeat (2 * F) @(negedge clk);

    // Back-to-back with valid held high.
    send(24'hA5A5A5, 24'h5A5A5A, 1'b1);
    send(24'h000FFF, 24'hFFF000, 1'b1);
    send(24'hC0FFEE, 24'h0BADF0, 1'b1);
    send(24'h123456, 24'h123456, 1'b0);

    // Starvation: one underflow pulse per frame.
    repeat (3 * F) @(negedge clk);

    // Offer exactly on the frame-start edge with holding empty.
    wait_cnt(0);
    send(24'hABCDEF, 24'h13579B, 1'b0);
    repeat (2 * F + 20) @(negedge clk);

    // Reset in the middle of the right slot.
    wait_cnt(200);
    send(24'h55AA55, 24'hFFFFFF, 1'b0);
    wait_cnt(0);
    wait_cnt(300);
    check("pre_reset_sdout", 64'(sdout), 64'(1));
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", 64'({ready, mclk, sclk, lrck, sdout, uf}), 64'(0));
    exp_q.delete();
    primed_from = 1 << 30;
    last_s      = '0;
    repeat (3) @(negedge clk);
    check("ready_in_reset", 64'(ready), 64'(0));
    #2 rst_n = 1'b1;
    repeat (F + 50) @(negedge clk);

    check("frames_checked_enough", 64'(frames_checked >= 12), 64'(1));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
